// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out handshake bundle for bit_serializer.
// The master side feeds words and the bit strobe; the slave side is the serializer.
interface bit_serializer_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 10
);
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic               en;
    logic               sout;
    logic               sout_valid;
    logic               busy;
    logic [COUNT_W-1:0] words_sent;

    modport master (
        output in_data, in_valid, en,
        input  in_ready, sout, sout_valid, busy, words_sent
    );

    modport slave (
        input  in_data, in_valid, en,
        output in_ready, sout, sout_valid, busy, words_sent
    );
endinterface

// File: rtl/bit_serializer.sv
// Word-to-bit serializer with a one-entry holding register for gapless streaming
// and a wrapping count of fully shifted words.
module bit_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b1,
    parameter int unsigned COUNT_W    = 10
) (
    input  logic            clk,
    input  logic            rst,
    bit_serializer_if.slave bus
);
    localparam int unsigned        CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   hold_data_q;
    logic               hold_full_q;
    logic [WIDTH-1:0]   sh_data_q;
    logic [WIDTH-1:0]   sh_data_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [COUNT_W-1:0] words_sent_q;
    logic               accept;

    // Shift toward whichever end drives sout.
    always_comb begin
        sh_data_d = '0;
        if (MSB_FIRST) sh_data_d = {sh_data_q[WIDTH-2:0], 1'b0};
        else           sh_data_d = {1'b0, sh_data_q[WIDTH-1:1]};
    end

    assign accept = bus.in_valid & ~hold_full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_data_q  <= '0;
            hold_full_q  <= 1'b0;
            sh_data_q    <= '0;
            bit_cnt_q    <= '0;
            words_sent_q <= '0;
        end else begin
            // Accept and transfer never coincide: one needs the buffer empty, the other full.
            if (accept) begin
                hold_data_q <= bus.in_data;
                hold_full_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (hold_full_q) begin
                        sh_data_q   <= hold_data_q;
                        hold_full_q <= 1'b0;
                        bit_cnt_q   <= '0;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.en) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            words_sent_q <= words_sent_q + 1'b1;
                            bit_cnt_q    <= '0;
                            if (hold_full_q) begin
                                sh_data_q   <= hold_data_q;
                                hold_full_q <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            sh_data_q <= sh_data_d;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = ~hold_full_q;
    assign bus.sout_valid = (state_q == SHIFT);
    assign bus.sout       = (state_q == SHIFT)
                            ? (MSB_FIRST ? sh_data_q[WIDTH-1] : sh_data_q[0])
                            : IDLE_LEVEL;
    assign bus.busy       = (state_q == SHIFT) | hold_full_q;
    assign bus.words_sent = words_sent_q;
endmodule
